// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Fetch stage of the MIPS datapath: owns the program counter, presents it to a
// zero-wait combinational instruction memory and latches the returned word
// together with PC+4 into the IF/ID pipeline register. Supports stall, branch
// redirect with flush, a HALT state entered on HALT_WORD, and a fetch counter.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] ifid_instr_r;
  logic [31:0] ifid_instr_s;
  logic [31:0] ifid_pc4_r;
  logic [31:0] ifid_pc4_s;
  logic        ifid_valid_r;
  logic        ifid_valid_s;
  logic [31:0] fetch_count_r;
  logic [31:0] fetch_count_s;
  logic        halted_r;
  logic        halted_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] branch_pc_s;

  // Sequential address arithmetic; wraps naturally modulo 2^32.
  assign pc_plus4_s  = pc_r + 32'd4;
  // Redirect target is forced word-aligned so PC[1:0] stays zero.
  assign branch_pc_s = BranchTarget & 32'hFFFF_FFFC;

  // Next-state and next-register computation; branch beats stall beats halt hold.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    ifid_instr_s  = ifid_instr_r;
    ifid_pc4_s    = ifid_pc4_r;
    ifid_valid_s  = ifid_valid_r;
    fetch_count_s = fetch_count_r;
    if (BranchTaken) begin
      // Redirect and flush; any word fetched this cycle (even HALT_WORD) is dropped.
      pc_s         = branch_pc_s;
      ifid_instr_s = 32'h0000_0000;
      ifid_pc4_s   = 32'h0000_0000;
      ifid_valid_s = 1'b0;
      state_s      = ST_RUN;
    end else if (Stall) begin
      // Everything holds, in either state.
      state_s = state_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          ifid_instr_s  = IMemInstruction;
          ifid_pc4_s    = pc_plus4_s;
          ifid_valid_s  = 1'b1;
          pc_s          = pc_plus4_s;
          fetch_count_s = fetch_count_r + 32'd1;
          if (IMemInstruction == HALT_WORD) begin
            state_s = ST_HALT;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_HALT: begin
          // Feed bubbles to decode while the PC sits still.
          ifid_instr_s = 32'h0000_0000;
          ifid_valid_s = 1'b0;
          state_s      = ST_HALT;
        end
        default: begin
          state_s = ST_RUN;
        end
      endcase
    end
    halted_s = (state_s == ST_HALT);
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      ifid_instr_r  <= 32'h0000_0000;
      ifid_pc4_r    <= 32'h0000_0000;
      ifid_valid_r  <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      ifid_instr_r  <= ifid_instr_s;
      ifid_pc4_r    <= ifid_pc4_s;
      ifid_valid_r  <= ifid_valid_s;
      fetch_count_r <= fetch_count_s;
      halted_r      <= halted_s;
    end
  end

  assign IMemAddress       = pc_r;
  assign IF_ID_Instruction = ifid_instr_r;
  assign IF_ID_PCPlus4     = ifid_pc4_r;
  assign IF_ID_Valid       = ifid_valid_r;
  assign Halted            = halted_r;
  assign FetchCount        = fetch_count_r;

endmodule
